zap_cp15_ctrl_gen: RTL

Parametrised next-generation system control coprocessor for the ZAP core. It services MRC/MCR transfers on the coprocessor bus, holds the MMU/cache configuration registers, captures abort status from the memory control unit, and drives cache/TLB maintenance strobes. Compared with the current CP15 block it adds:
- a configurable coprocessor number and register-file depth;
- CRm-decoded maintenance (separate I/D cache and TLB invalidates);
- a user-mode undefined-access flag;
- a sticky fault-capture mode;
- a FCSE PID register.

---
 rtl/zap_cp15_ctrl_gen.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/zap_cp15_ctrl_gen.sv
// zap_cp15_ctrl_gen: parametrised CP15 system control coprocessor (MRC/MCR, MMU/cache config, abort capture, maintenance strobes)
// Ports: i_clk/i_reset clock and sync reset; i_cp_word/i_cp_dav/o_cp_done/o_cp_undef coprocessor bus;
// i_cpsr current CPSR; o_reg_* / i_reg_rd_data core register-file access; i_fault_valid/i_fsr/i_far abort capture;
// o_dac/o_baddr/o_pid/o_*_en/o_sr configuration outputs; o_*_inv maintenance strobes.
module zap_cp15_ctrl_gen #(
    parameter int          PHY_REGS     = 64,
    parameter int          CP_NUM       = 15,
    parameter int          NUM_CREGS    = 16,
    parameter logic [31:0] ID_VALUE     = 32'h4107_B000,
    parameter bit          STICKY_FAULT = 1'b0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [31:0]                 i_cp_word,
    input  logic                        i_cp_dav,
    output logic                        o_cp_done,
    output logic                        o_cp_undef,
    input  logic [31:0]                 i_cpsr,
    output logic                        o_reg_en,
    output logic [31:0]                 o_reg_wr_data,
    input  logic [31:0]                 i_reg_rd_data,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_index,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_index,
    input  logic                        i_fault_valid,
    input  logic [31:0]                 i_fsr,
    input  logic [31:0]                 i_far,
    output logic [31:0]                 o_dac,
    output logic [31:0]                 o_baddr,
    output logic [6:0]                  o_pid,
    output logic                        o_icache_inv,
    output logic                        o_dcache_inv,
    output logic                        o_tlb_inv,
    output logic                        o_dcache_en,
    output logic                        o_icache_en,
    output logic                        o_mmu_en,
    output logic [1:0]                  o_sr
);
    localparam int IW = $clog2(PHY_REGS);
    localparam logic [4:0] FIQ = 5'h11, IRQ = 5'h12, SVC = 5'h13, ABT = 5'h17, UND = 5'h1B, USR = 5'h10;
    typedef enum logic [2:0] {IDLE, ACTIVE, READ_DLY, READ, DONE, TERM} state_t;
    state_t      state;
    logic [31:0] creg [NUM_CREGS];
    logic        done_q;
    logic [3:0]  crn, crm, rd;
    logic [4:0]  mode;
    logic        cp_hit, usr_hit;
    logic [31:0] rd_val;
    logic        unused_ok;
    // Banked layout: r0-r15 at 0-15, FIQ r8-r14 at 16-22, then r13/r14 pairs for IRQ, SVC, ABT, UND at 23-30.
    function automatic logic [IW-1:0] xlate(input logic [3:0] r, input logic [4:0] m);
        int p;
        p = int'(r);
        if (m == FIQ && r >= 4'd8 && r <= 4'd14)
            p = 16 + int'(r) - 8;
        else if (r == 4'd13 || r == 4'd14)
            p = m == IRQ ? 23 + int'(r) - 13 :
                m == SVC ? 25 + int'(r) - 13 :
                m == ABT ? 27 + int'(r) - 13 :
                m == UND ? 29 + int'(r) - 13 : p;
        return IW'(p);
    endfunction
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    assign crn       = i_cp_word[19:16];
    assign rd        = i_cp_word[15:12];
    assign crm       = i_cp_word[3:0];
    assign mode      = i_cpsr[4:0];
    assign cp_hit    = i_cp_dav && i_cp_word[11:8] == 4'(CP_NUM);
    // User-mode rejection is answered combinationally in the same cycle the request is seen.
    assign usr_hit   = !i_reset && state == IDLE && cp_hit && mode == USR;
    assign o_cp_done  = done_q | usr_hit;
    assign o_cp_undef = usr_hit;
    assign unused_ok = ^{i_cpsr[27:5], i_cp_word[27:21], i_cp_word[7:4]};
    always_comb begin
        rd_val = 32'd0;
        if (crn == 4'd0)
            rd_val = ID_VALUE;
        else if (int'(crn) < NUM_CREGS)
            rd_val = creg[crn];
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            done_q         <= 1'b0;
            o_reg_en       <= 1'b0;
            o_reg_wr_data  <= '0;
            o_reg_wr_index <= '0;
            o_reg_rd_index <= '0;
            o_icache_inv   <= 1'b0;
            o_dcache_inv   <= 1'b0;
            o_tlb_inv      <= 1'b0;
            for (int i = 0; i < NUM_CREGS; i++)
                creg[i] <= '0;
        end else begin
            done_q       <= 1'b0;
            o_reg_en     <= 1'b0;
            o_icache_inv <= 1'b0;
            o_dcache_inv <= 1'b0;
            o_tlb_inv    <= 1'b0;
            // Capture comes first so a same-cycle MCR commit to c5/c6 below wins.
            if (i_fault_valid && !(STICKY_FAULT && creg[5][3:0] != 4'd0)) begin
                creg[5] <= i_fsr;
                creg[6] <= i_far;
            end
            case (state)
                IDLE: if (cp_hit && mode != USR) state <= ACTIVE;
                ACTIVE: begin
                    if (!cond_ok(i_cp_word[31:28], i_cpsr[31:28])) begin
                        state <= DONE;
                    end else if (i_cp_word[20]) begin
                        o_reg_en       <= rd != 4'd15;
                        o_reg_wr_index <= xlate(rd, mode);
                        o_reg_wr_data  <= rd_val;
                        state          <= DONE;
                    end else begin
                        o_reg_en       <= 1'b1;
                        o_reg_rd_index <= xlate(rd, mode);
                        o_reg_wr_index <= IW'(PHY_REGS - 1);
                        state          <= READ_DLY;
                    end
                end
                READ_DLY: state <= READ;
                READ: begin
                    if (int'(crn) < NUM_CREGS && crn != 4'd0 && crn != 4'd7 && crn != 4'd8)
                        creg[crn] <= crn == 4'd13 ? {i_reg_rd_data[31:25], 25'd0} : i_reg_rd_data;
                    o_icache_inv <= crn == 4'd7 && (crm == 4'd5 || crm == 4'd7);
                    o_dcache_inv <= crn == 4'd7 && (crm == 4'd6 || crm == 4'd7);
                    o_tlb_inv    <= crn == 4'd8;
                    state        <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= TERM;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign o_dac   = creg[3];
    assign o_baddr = creg[2];
    assign o_pid   = creg[13][31:25];
    assign o_sr    = {creg[1][8], creg[1][9]};
`ifdef FORCE_DCACHE_EN
    assign o_dcache_en = 1'b1;
`else
    assign o_dcache_en = creg[1][2];
`endif
`ifdef FORCE_ICACHE_EN
    assign o_icache_en = 1'b1;
`else
    assign o_icache_en = creg[1][12];
`endif
`ifdef FORCE_MMU_EN
    assign o_mmu_en = 1'b1;
`else
    assign o_mmu_en = creg[1][0];
`endif
endmodule
